// File: rtl/serial_framer.sv
// Frames parallel words onto a serial line: start, data LSB-first, optional parity, stop bit(s).
// Parity is compiled in only when the SERIAL_FRAMER_PARITY_EN macro is defined.
module serial_framer #(
  parameter int DATA_W      = 8,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int ODD_PARITY  = 0
) (
  input  logic              in,
  input  logic              reset,
  input  logic              rate_in,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  if (DATA_W < 1 || DATA_W > 16 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      SYNC_STAGES < 2 || ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_param
    $error("serial_framer: parameter out of range");
  end

`ifdef SERIAL_FRAMER_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                  state_r;
  logic [SYNC_STAGES-1:0]  sync_r;
  logic                    hist_r;
  logic [DATA_W-1:0]       shreg_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic                    stop_cnt_r;
  logic                    ready_r;
  logic                    tx_r;
  logic                    busy_r;
  logic                    frame_done_r;
  logic                    tick_s;

`ifdef SERIAL_FRAMER_PARITY_EN
  logic                    par_r;

  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ (ODD_PARITY != 0);
  endfunction
`endif

  // Rising edge of the synchronized rate signal marks one bit period.
  assign tick_s = sync_r[SYNC_STAGES-1] & ~hist_r;

  // Rate synchronizer, handshake and framing state machine.
  always_ff @(posedge in) begin
    if (reset) begin
      state_r      <= S_IDLE;
      sync_r       <= '0;
      hist_r       <= 1'b0;
      shreg_r      <= '0;
      bit_cnt_r    <= '0;
      stop_cnt_r   <= 1'b0;
      ready_r      <= 1'b0;
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef SERIAL_FRAMER_PARITY_EN
      par_r        <= 1'b0;
`endif
    end else begin
      sync_r       <= {sync_r[SYNC_STAGES-2:0], rate_in};
      hist_r       <= sync_r[SYNC_STAGES-1];
      frame_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          tx_r <= 1'b1;
          if (valid && ready_r) begin
            shreg_r <= data;
`ifdef SERIAL_FRAMER_PARITY_EN
            par_r   <= calc_parity(data);
`endif
            state_r <= S_WAIT;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            ready_r <= 1'b1;
          end
        end
        S_WAIT: begin
          if (tick_s) begin
            tx_r    <= 1'b0;
            state_r <= S_START;
          end
        end
        S_START: begin
          if (tick_s) begin
            tx_r      <= shreg_r[0];
            shreg_r   <= shreg_r >> 1'b1;
            bit_cnt_r <= CNT_W'(0);
            state_r   <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick_s) begin
            if (bit_cnt_r == LAST_BIT) begin
`ifdef SERIAL_FRAMER_PARITY_EN
              tx_r       <= par_r;
              state_r    <= S_PARITY;
`else
              tx_r       <= 1'b1;
              stop_cnt_r <= 1'b0;
              state_r    <= S_STOP;
`endif
            end else begin
              tx_r      <= shreg_r[0];
              shreg_r   <= shreg_r >> 1'b1;
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
`ifdef SERIAL_FRAMER_PARITY_EN
        S_PARITY: begin
          if (tick_s) begin
            tx_r       <= 1'b1;
            stop_cnt_r <= 1'b0;
            state_r    <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick_s) begin
            if (stop_cnt_r == LAST_STOP) begin
              state_r      <= S_IDLE;
              busy_r       <= 1'b0;
              frame_done_r <= 1'b1;
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          tx_r    <= 1'b1;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = ready_r;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule
